// File: rtl/gmrr_phase_addr_gen_if.sv
// Handshake bundle for gmrr_phase_addr_gen: increment load, trigger stream, address and fraction streams.
// The slave modport is the generator side; the master modport drives triggers and consumes outputs.
interface gmrr_phase_addr_gen_if #(
  parameter int AWIDTH = 10,
  parameter int FWIDTH = 16
);
  logic [AWIDTH+FWIDTH-1:0] set_inc;
  logic                     set_stb;
  logic                     i_tlast;
  logic                     i_tvalid;
  logic                     i_tready;
  logic [AWIDTH-1:0]        o_tdata;
  logic                     o_tlast;
  logic                     o_tvalid;
  logic                     o_tready;
  logic [FWIDTH-1:0]        f_tdata;
  logic                     f_tlast;
  logic                     f_tvalid;
  logic                     f_tready;

  modport master (
    output set_inc, set_stb, i_tlast, i_tvalid, o_tready, f_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid, f_tdata, f_tlast, f_tvalid
  );

  modport slave (
    input  set_inc, set_stb, i_tlast, i_tvalid, o_tready, f_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid, f_tdata, f_tlast, f_tvalid
  );
endinterface

// File: rtl/gmrr_phase_addr_gen.sv
// Trigger-driven phase accumulator emitting coefficient-RAM addresses and interpolation fractions.
// Define GMRR_FRAC_OUT_EN to enable the f_* fraction stream; otherwise it is tied off.
module gmrr_phase_addr_gen #(
  parameter int AWIDTH              = 10,
  parameter int FWIDTH              = 16,
  parameter int PHASE_RESET_ON_LAST = 1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  clear,
  gmrr_phase_addr_gen_if.slave bus
);

  localparam int PW = AWIDTH + FWIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [PW-1:0]     phase_p0;
  logic [PW-1:0]     inc;
  logic [PW-1:0]     pend;
  logic              pending;
  logic [AWIDTH-1:0] o_data_p1;
  logic              o_last_p1;
  logic              o_vld_p1;
  logic              ready_in;
  logic              accept;
  logic              transfer;

  function automatic logic [PW-1:0] phase_next(input logic [PW-1:0] p,
                                               input logic [PW-1:0] step,
                                               input logic          last);
    if (last && (PHASE_RESET_ON_LAST != 0)) return '0;
    return p + step;
  endfunction

  assign accept   = bus.i_tvalid & ready_in;
  // A pending increment only lands between packets, so INC is frozen inside a packet.
  assign transfer = pending & (((state == IDLE) & ~accept) | (accept & bus.i_tlast));

  assign bus.i_tready = ready_in;
  assign bus.o_tdata  = o_data_p1;
  assign bus.o_tlast  = o_last_p1;
  assign bus.o_tvalid = o_vld_p1;

`ifdef GMRR_FRAC_OUT_EN
  logic [FWIDTH-1:0] f_data_p1;
  logic              f_last_p1;
  logic              f_vld_p1;

  assign ready_in     = (~o_vld_p1 | bus.o_tready) & (~f_vld_p1 | bus.f_tready);
  assign bus.f_tdata  = f_data_p1;
  assign bus.f_tlast  = f_last_p1;
  assign bus.f_tvalid = f_vld_p1;
`else
  logic unused_f_tready;

  assign unused_f_tready = bus.f_tready;
  assign ready_in        = ~o_vld_p1 | bus.o_tready;
  assign bus.f_tdata     = '0;
  assign bus.f_tlast     = 1'b0;
  assign bus.f_tvalid    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state     <= IDLE;
      phase_p0  <= '0;
      inc       <= '0;
      pend      <= '0;
      pending   <= 1'b0;
      o_data_p1 <= '0;
      o_last_p1 <= 1'b0;
      o_vld_p1  <= 1'b0;
`ifdef GMRR_FRAC_OUT_EN
      f_data_p1 <= '0;
      f_last_p1 <= 1'b0;
      f_vld_p1  <= 1'b0;
`endif
    end else begin
      if (transfer) begin
        inc     <= pend;
        pending <= 1'b0;
      end
      // A coincident strobe wins the flag: old PEND moves to INC, new value waits.
      if (bus.set_stb) begin
        pend    <= bus.set_inc;
        pending <= 1'b1;
      end

      // Stage p0 -> p1: accepted trigger snapshots the phase, accumulator advances.
      if (accept) begin
        state    <= bus.i_tlast ? IDLE : RUN;
        phase_p0 <= phase_next(phase_p0, inc, bus.i_tlast);
      end

      if (o_vld_p1 && bus.o_tready) o_vld_p1 <= 1'b0;
      if (accept) begin
        o_vld_p1  <= 1'b1;
        o_data_p1 <= phase_p0[PW-1:FWIDTH];
        o_last_p1 <= bus.i_tlast;
      end
`ifdef GMRR_FRAC_OUT_EN
      if (f_vld_p1 && bus.f_tready) f_vld_p1 <= 1'b0;
      if (accept) begin
        f_vld_p1  <= 1'b1;
        f_data_p1 <= phase_p0[FWIDTH-1:0];
        f_last_p1 <= bus.i_tlast;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gmrr_phase_addr_gen.sv
// Randomised and directed bench for gmrr_phase_addr_gen; expected beats come from k*INC per packet.
module tb_gmrr_phase_addr_gen;
  localparam int AW = 10;
  localparam int FW = 16;
  localparam int PW = AW + FW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [FW-1:0] f;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   f_valid_cnt = 0;
  int   rdy_mode = 0;

  beat_t exp_q[$];
  beat_t got_o[$];
  beat_t got_f[$];

  logic [PW-1:0] m_inc, m_pend;
  bit            m_pending;
  longint        m_k;

  gmrr_phase_addr_gen_if #(.AWIDTH(AW), .FWIDTH(FW)) bus ();

  gmrr_phase_addr_gen #(
    .AWIDTH(AW), .FWIDTH(FW), .PHASE_RESET_ON_LAST(1)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Beats are taken on the edge following a negedge where valid & ready hold.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (bus.o_tvalid && bus.o_tready) got_o.push_back('{a: bus.o_tdata, f: '0, l: bus.o_tlast});
      if (bus.f_tvalid && bus.f_tready) got_f.push_back('{a: '0, f: bus.f_tdata, l: bus.f_tlast});
    end
    if (bus.f_tvalid) f_valid_cnt <= f_valid_cnt + 1;
  end

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 1) begin
        bus.o_tready = 1'b1;
        bus.f_tready = ~bus.f_tready;
      end else if (rdy_mode == 2) begin
        bus.o_tready = 1'($urandom_range(0, 1));
        bus.f_tready = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic void model_reset();
    m_inc = '0; m_pend = '0; m_pending = 0; m_k = 0;
    exp_q.delete();
  endfunction

  // Within a packet beat k carries phase k*INC modulo 2^PW; a new increment takes effect at packet start.
  function automatic void model_accept(bit last);
    longint unsigned prod;
    logic [PW-1:0]   ph;
    if (m_k == 0 && m_pending) begin m_inc = m_pend; m_pending = 0; end
    prod = longint'(m_k) * longint'(m_inc);
    ph = prod[PW-1:0];
    exp_q.push_back('{a: ph[PW-1:FW], f: ph[FW-1:0], l: last});
    m_k = last ? 0 : m_k + 1;
  endfunction

  task automatic clr_q();
    got_o.delete(); got_f.delete(); exp_q.delete();
  endtask

  task automatic set_ready(input bit o, input bit f);
    rdy_mode = 0; bus.o_tready = o; bus.f_tready = f;
  endtask

  task automatic set_increment(input logic [PW-1:0] v);
    bus.set_inc = v; bus.set_stb = 1'b1;
    @(posedge clk); #1;
    bus.set_stb = 1'b0;
    @(posedge clk); #1;
    m_pend = v; m_pending = 1;
  endtask

  task automatic send(input bit last);
    int n = 0;
    bit rdy;
    bus.i_tvalid = 1'b1; bus.i_tlast = last;
    do begin
      @(negedge clk); rdy = bus.i_tready;
      @(posedge clk); #1; n++;
    end while (!rdy && n < 200);
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0;
    total++;
    if (rdy) model_accept(last);
    else begin bad++; $display("FAIL trigger_accept i_tready=%0b required=1 within 200 cycles", rdy); end
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.o_tvalid || bus.f_tvalid) && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (bus.o_tvalid || bus.f_tvalid) begin
      bad++; $display("FAIL drain o_tvalid=%0b f_tvalid=%0b required=0", bus.o_tvalid, bus.f_tvalid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; set_ready(0, 0);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.o_tvalid, bus.o_tlast, bus.o_tdata, bus.f_tvalid, bus.f_tlast, bus.f_tdata} !== '0) begin
      bad++; $display("FAIL reset_outputs o=%0b/%0b/%0h f=%0b/%0b/%0h required=all 0",
                      bus.o_tvalid, bus.o_tlast, bus.o_tdata, bus.f_tvalid, bus.f_tlast, bus.f_tdata);
    end
    total++;
    if (bus.i_tready !== 1'b1) begin bad++; $display("FAIL reset_i_tready got=%0b required=1", bus.i_tready); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [AW-1:0] ea[4] = '{10'd0, 10'd1, 10'd3, 10'd4};
    logic [FW-1:0] ef[4] = '{16'h0, 16'h8000, 16'h0, 16'h8000};
`ifdef GMRR_FRAC_OUT_EN
    set_ready(1, 1);
`else
    set_ready(1, 0);
`endif
    set_increment(26'h18000);
    clr_q();
    for (int i = 0; i < 4; i++) send(i == 3);
    drain();
    total++;
    if (got_o.size() != 4) begin bad++; $display("FAIL basic_count got=%0d required=4", got_o.size()); end
    for (int i = 0; i < 4 && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== ea[i] || got_o[i].l !== (i == 3)) begin
        bad++; $display("FAIL basic_o%0d got=%0d/%0b required=%0d/%0b", i, got_o[i].a, got_o[i].l, ea[i], i == 3);
      end
    end
`ifdef GMRR_FRAC_OUT_EN
    total++;
    if (got_f.size() != 4) begin bad++; $display("FAIL basic_f_count got=%0d required=4", got_f.size()); end
    for (int i = 0; i < 4 && i < got_f.size(); i++) begin
      total++;
      if (got_f[i].f !== ef[i] || got_f[i].l !== (i == 3)) begin
        bad++; $display("FAIL basic_f%0d got=%0h/%0b required=%0h/%0b", i, got_f[i].f, got_f[i].l, ef[i], i == 3);
      end
    end
`else
    total++;
    if (f_valid_cnt != 0 || got_f.size() != 0 || ef[1] === 16'h0) begin
      bad++; $display("FAIL basic_f_off f_tvalid_cycles=%0d required=0", f_valid_cnt);
    end
`endif
  endtask

  task automatic test_wrap();
    set_ready(1, 1);
    set_increment(26'h10000);
    clr_q();
    for (int i = 0; i < 1023; i++) send(1'b0);
    drain();
    total++;
    if (got_o.size() != exp_q.size()) begin
      bad++; $display("FAIL wrap_ramp_count got=%0d required=%0d", got_o.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== exp_q[i].a || got_o[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL wrap_ramp%0d got=%0d required=%0d", i, got_o[i].a, exp_q[i].a);
      end
    end
    clr_q();
    send(1'b0);
    send(1'b1);
    drain();
    total++;
    if (got_o.size() != 2) begin bad++; $display("FAIL wrap_count got=%0d required=2", got_o.size()); end
    else begin
      total++;
      if (got_o[0].a !== 10'd1023 || got_o[1].a !== 10'd0) begin
        bad++; $display("FAIL wrap_addr got=%0d,%0d required=1023,0", got_o[0].a, got_o[1].a);
      end
    end
  endtask

  task automatic test_inc_change();
    logic [AW-1:0] ea[7] = '{10'd0, 10'd1, 10'd2, 10'd3, 10'd0, 10'd2, 10'd4};
    logic          el[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    set_ready(1, 1);
    clr_q();
    send(1'b0); send(1'b0);
    set_increment(26'h20000);
    send(1'b0); send(1'b1);
    send(1'b0); send(1'b0); send(1'b1);
    drain();
    total++;
    if (got_o.size() != 7) begin bad++; $display("FAIL incchg_count got=%0d required=7", got_o.size()); end
    for (int i = 0; i < 7 && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== ea[i] || got_o[i].l !== el[i]) begin
        bad++; $display("FAIL incchg_o%0d got=%0d/%0b required=%0d/%0b", i, got_o[i].a, got_o[i].l, ea[i], el[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    set_ready(1, 1);
    clr_q();
    send(1'b0);
    @(posedge clk); #1;
    set_ready(0, 0);
    send(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 10'd2 || bus.i_tready !== 1'b0) begin
        bad++; $display("FAIL stall%0d o_tvalid/o_tdata/i_tready=%0b/%0d/%0b required=1/2/0",
                        i, bus.o_tvalid, bus.o_tdata, bus.i_tready);
      end
      @(posedge clk); #1;
    end
    set_ready(1, 1);
    send(1'b1);
    rdy_mode = 1;
    for (int p = 0; p < 4; p++) begin
      set_increment(26'($urandom_range(0, 26'h3FFFF)));
      for (int b = 0, n = $urandom_range(1, 5); b < n; b++) send(b == n - 1);
    end
    drain();
    rdy_mode = 0;
    total++;
    if (got_o.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_count got=%0d required=%0d", got_o.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== exp_q[i].a || got_o[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL bp_o%0d got=%0h/%0b required=%0h/%0b", i, got_o[i].a, got_o[i].l, exp_q[i].a, exp_q[i].l);
      end
    end
`ifdef GMRR_FRAC_OUT_EN
    total++;
    if (got_f.size() != exp_q.size()) begin
      bad++; $display("FAIL bp_f_count got=%0d required=%0d", got_f.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_f.size(); i++) begin
      total++;
      if (got_f[i].f !== exp_q[i].f || got_f[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL bp_f%0d got=%0h/%0b required=%0h/%0b", i, got_f[i].f, got_f[i].l, exp_q[i].f, exp_q[i].l);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    set_ready(1, 1);
    set_increment(26'h18000);
    send(1'b0); send(1'b0);
    set_ready(0, 0);
    total++;
`ifdef GMRR_FRAC_OUT_EN
    if (bus.o_tvalid !== 1'b1 || bus.f_tvalid !== 1'b1) begin
`else
    if (bus.o_tvalid !== 1'b1 || bus.o_tdata !== 10'd1) begin
`endif
      bad++; $display("FAIL midrst_pre o_tvalid=%0b f_tvalid=%0b o_tdata=%0d required=1/1/1",
                      bus.o_tvalid, bus.f_tvalid, bus.o_tdata);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (bus.o_tvalid !== 1'b0 || bus.f_tvalid !== 1'b0 || bus.o_tdata !== '0) begin
      bad++; $display("FAIL midrst_post o_tvalid=%0b f_tvalid=%0b o_tdata=%0d required=0/0/0",
                      bus.o_tvalid, bus.f_tvalid, bus.o_tdata);
    end
    model_reset();
    clr_q();
    set_ready(1, 1);
    send(1'b1);
    drain();
    total++;
    if (got_o.size() != 1 || got_o[0].a !== 10'd0 || got_o[0].l !== 1'b1) begin
      bad++; $display("FAIL midrst_first count=%0d addr=%0d required=1 beat addr 0", got_o.size(),
                      got_o.size() > 0 ? got_o[0].a : 10'h3FF);
    end
`ifdef GMRR_FRAC_OUT_EN
    total++;
    if (got_f.size() != 1 || got_f[0].f !== 16'h0) begin
      bad++; $display("FAIL midrst_frac count=%0d required=1 beat frac 0", got_f.size());
    end
`endif
  endtask

  task automatic test_clear_priority();
    set_ready(1, 1);
    set_increment(26'h18000);
    send(1'b0);
    drain();
    clear = 1'b1;
    bus.set_inc = 26'h30000; bus.set_stb = 1'b1;
    bus.i_tvalid = 1'b1; bus.i_tlast = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0; bus.set_stb = 1'b0; bus.i_tvalid = 1'b0;
    total++;
    if (bus.o_tvalid !== 1'b0) begin bad++; $display("FAIL clear_trigger o_tvalid=%0b required=0", bus.o_tvalid); end
    model_reset();
    clr_q();
    repeat (2) @(posedge clk);
    #1;
    send(1'b0); send(1'b1);
    drain();
    total++;
    if (got_o.size() != 2) begin bad++; $display("FAIL clear_count got=%0d required=2", got_o.size()); end
    else begin
      total++;
      if (got_o[0].a !== 10'd0 || got_o[1].a !== 10'd0) begin
        bad++; $display("FAIL clear_addr got=%0d,%0d required=0,0", got_o[0].a, got_o[1].a);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    set_ready(1, 1);
    set_increment(26'($urandom_range(1, 26'hFFFFF)));
    clr_q();
    c0 = cyc;
    for (int i = 0; i < 8; i++) send(i == 7);
    total++;
    if (cyc - c0 != 8) begin bad++; $display("FAIL b2b_cycles got=%0d required=8", cyc - c0); end
    drain();
    total++;
    if (got_o.size() != 8) begin bad++; $display("FAIL b2b_count got=%0d required=8", got_o.size()); end
    for (int i = 0; i < 8 && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== exp_q[i].a || got_o[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL b2b_o%0d got=%0h required=%0h", i, got_o[i].a, exp_q[i].a);
      end
    end
  endtask

  task automatic test_random();
    clr_q();
    rdy_mode = 2;
    for (int p = 0; p < 25; p++) begin
      if ($urandom_range(0, 7) == 0) set_increment('0);
      else set_increment(26'($urandom_range(0, 26'h7FFFF)));
      for (int b = 0, n = $urandom_range(1, 6); b < n; b++) begin
        send(b == n - 1);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
    end
    rdy_mode = 0;
    bus.o_tready = 1'b1; bus.f_tready = 1'b1;
    drain();
    total++;
    if (got_o.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d required=%0d", got_o.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_o.size(); i++) begin
      total++;
      if (got_o[i].a !== exp_q[i].a || got_o[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL rand_o%0d got=%0h/%0b required=%0h/%0b", i, got_o[i].a, got_o[i].l, exp_q[i].a, exp_q[i].l);
      end
    end
`ifdef GMRR_FRAC_OUT_EN
    total++;
    if (got_f.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_f_count got=%0d required=%0d", got_f.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_f.size(); i++) begin
      total++;
      if (got_f[i].f !== exp_q[i].f || got_f[i].l !== exp_q[i].l) begin
        bad++; $display("FAIL rand_f%0d got=%0h/%0b required=%0h/%0b", i, got_f[i].f, got_f[i].l, exp_q[i].f, exp_q[i].l);
      end
    end
`else
    total++;
    if (f_valid_cnt != 0) begin bad++; $display("FAIL rand_f_off f_tvalid_cycles=%0d required=0", f_valid_cnt); end
`endif
  endtask

  initial begin
    bus.set_inc = '0; bus.set_stb = 1'b0;
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0;
    bus.o_tready = 1'b0; bus.f_tready = 1'b0;
    reset = 1'b1; clear = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_inc_change();
    test_backpressure();
    test_mid_reset();
    test_clear_priority();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
